// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared types and constants for the multicycle CPU controller.
//   - state_e   : FSM state encodings (4 bits)
//   - OPC_*/OP_*: decoded opcode/op field values
//   - NSEL_*/VSEL_*: register-file port select and write-back source codes
//   - ctrl_t    : bundle of all controller output strobes
//   - dec_target: DECODE successor for the base ISA (ST_WAIT = undecodable)
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_WAIT      = 4'd0,
        ST_DECODE    = 4'd1,
        ST_WRITE_IMM = 4'd2,
        ST_GET_A     = 4'd3,
        ST_GET_B     = 4'd4,
        ST_ALU       = 4'd5,
        ST_WRITE_REG = 4'd6,
        ST_HALT      = 4'd7
    } state_e;

    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b01;

    typedef struct packed {
        logic       w;
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       write;
        logic       illegal;
        logic       halted;
    } ctrl_t;

    // Where DECODE goes for the base ISA. ST_WAIT means "undecodable";
    // the optional halt opcode is layered on top by the callers.
    function automatic state_e dec_target(input logic [2:0] opc, input logic [1:0] op);
        state_e t;
        t = ST_WAIT;
        case (opc)
            OPC_MOV: begin
                if (op == OP_MOV_IMM)      t = ST_WRITE_IMM;
                else if (op == OP_MOV_REG) t = ST_GET_B;
            end
            OPC_ALU: t = (op == OP_MVN) ? ST_GET_B : ST_GET_A;
            default: t = ST_WAIT;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/cpu_ctrl_outdec.sv
// cpu_ctrl_outdec: combinational Moore output decoder for cpu_controller.
// Optional: CPU_CTRL_HALT_EN adds the HALT state (halted=1) and stops
// opcode 111 from being flagged illegal.
// Ports:
//   state  in  current FSM state
//   opc    in  latched opcode
//   op     in  latched op
//   ctrl   out all datapath strobes plus w/illegal/halted
module cpu_ctrl_outdec
    import cpu_ctrl_pkg::*;
#(
    parameter int STATE_BITS = 4
) (
    input  logic [STATE_BITS-1:0] state,
    input  logic [2:0]            opc,
    input  logic [1:0]            op,
    output ctrl_t                 ctrl
);

    logic is_cmp;
    logic zero_a;
    logic undecodable;

    assign is_cmp = (opc == OPC_ALU) && (op == OP_CMP);
    // MOV reg and MVN pass B through the ALU, so A is forced to zero.
    assign zero_a = (opc == OPC_MOV) || ((opc == OPC_ALU) && (op == OP_MVN));

`ifdef CPU_CTRL_HALT_EN
    assign undecodable = (dec_target(opc, op) == ST_WAIT) && (opc != OPC_HALT);
`else
    assign undecodable = (dec_target(opc, op) == ST_WAIT);
`endif

    always_comb begin
        ctrl      = '0;
        ctrl.nsel = NSEL_NONE;
        ctrl.vsel = VSEL_C;
        case (state)
            STATE_BITS'(ST_WAIT):   ctrl.w = 1'b1;
            STATE_BITS'(ST_DECODE): ctrl.illegal = undecodable;
            STATE_BITS'(ST_WRITE_IMM): begin
                ctrl.nsel  = NSEL_RN;
                ctrl.vsel  = VSEL_IMM;
                ctrl.write = 1'b1;
            end
            STATE_BITS'(ST_GET_A): begin
                ctrl.nsel  = NSEL_RN;
                ctrl.loada = 1'b1;
            end
            STATE_BITS'(ST_GET_B): begin
                ctrl.nsel  = NSEL_RM;
                ctrl.loadb = 1'b1;
            end
            STATE_BITS'(ST_ALU): begin
                ctrl.asel  = zero_a;
                ctrl.loads = is_cmp;
                ctrl.loadc = !is_cmp;
            end
            STATE_BITS'(ST_WRITE_REG): begin
                ctrl.nsel  = NSEL_RD;
                ctrl.vsel  = VSEL_C;
                ctrl.write = 1'b1;
            end
`ifdef CPU_CTRL_HALT_EN
            STATE_BITS'(ST_HALT): ctrl.halted = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: multicycle control FSM between the instruction decoder
// and the register-file/ALU datapath. Sequences read, execute and
// write-back; all outputs are Moore, decoded from state + latched fields.
// Optional: define CPU_CTRL_HALT_EN to make opcode 111 enter a HALT state
// that only rst_n leaves; otherwise 111 is illegal and halted is 0.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   s                 start, sampled only in WAIT
//   opcode, op        decoded instruction fields
//   w                 idle / ready for s
//   nsel, vsel        regfile port select, write-back source
//   loada/b/c, loads  datapath register loads
//   asel, bsel        ALU operand selects
//   write             regfile write enable
//   illegal, halted   undecodable-instruction pulse, halt status
module cpu_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int STATE_BITS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       write,
    output logic       illegal,
    output logic       halted
);

    logic [STATE_BITS-1:0] state, state_nxt;
    logic [2:0]            opc_q;
    logic [1:0]            op_q;
    ctrl_t                 ctrl;

    always_comb begin
        state_nxt = STATE_BITS'(ST_WAIT);
        case (state)
            STATE_BITS'(ST_WAIT):
                state_nxt = s ? STATE_BITS'(ST_DECODE) : STATE_BITS'(ST_WAIT);
            STATE_BITS'(ST_DECODE): begin
                state_nxt = STATE_BITS'(dec_target(opc_q, op_q));
`ifdef CPU_CTRL_HALT_EN
                if (opc_q == OPC_HALT) state_nxt = STATE_BITS'(ST_HALT);
`endif
            end
            STATE_BITS'(ST_WRITE_IMM): state_nxt = STATE_BITS'(ST_WAIT);
            STATE_BITS'(ST_GET_A):     state_nxt = STATE_BITS'(ST_GET_B);
            STATE_BITS'(ST_GET_B):     state_nxt = STATE_BITS'(ST_ALU);
            STATE_BITS'(ST_ALU):
                state_nxt = ((opc_q == OPC_ALU) && (op_q == OP_CMP))
                          ? STATE_BITS'(ST_WAIT) : STATE_BITS'(ST_WRITE_REG);
            STATE_BITS'(ST_WRITE_REG): state_nxt = STATE_BITS'(ST_WAIT);
`ifdef CPU_CTRL_HALT_EN
            STATE_BITS'(ST_HALT):      state_nxt = STATE_BITS'(ST_HALT);
`endif
            default:                   state_nxt = STATE_BITS'(ST_WAIT);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STATE_BITS'(ST_WAIT);
            opc_q <= '0;
            op_q  <= '0;
        end else begin
            state <= state_nxt;
            // Fields are captured once per instruction; later input
            // changes cannot disturb a sequence in flight.
            if ((state == STATE_BITS'(ST_WAIT)) && s) begin
                opc_q <= opcode;
                op_q  <= op;
            end
        end
    end

    cpu_ctrl_outdec #(.STATE_BITS(STATE_BITS)) u_outdec (
        .state (state),
        .opc   (opc_q),
        .op    (op_q),
        .ctrl  (ctrl)
    );

    assign w       = ctrl.w;
    assign nsel    = ctrl.nsel;
    assign vsel    = ctrl.vsel;
    assign loada   = ctrl.loada;
    assign loadb   = ctrl.loadb;
    assign loadc   = ctrl.loadc;
    assign loads   = ctrl.loads;
    assign asel    = ctrl.asel;
    assign bsel    = ctrl.bsel;
    assign write   = ctrl.write;
    assign illegal = ctrl.illegal;
    assign halted  = ctrl.halted;

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed bench for cpu_controller. Each step compares
// the full output vector {w,nsel,vsel,loada,loadb,loadc,loads,asel,bsel,
// write,illegal,halted} against a hand-written expectation.
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] op = 2'b00;
    logic       w, loada, loadb, loadc, loads, asel, bsel, write, illegal, halted;
    logic [2:0] nsel;
    logic [1:0] vsel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_controller dut (
        .clk(clk), .rst_n(rst_n), .s(s), .opcode(opcode), .op(op),
        .w(w), .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb),
        .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
        .write(write), .illegal(illegal), .halted(halted)
    );

    logic [14:0] obs;
    assign obs = {w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, illegal, halted};

    // Build an expected vector; bsel is always 0 in this ISA subset.
    function automatic logic [14:0] ev(input logic ew, input logic [2:0] ensel,
                                       input logic [1:0] evsel, input logic la,
                                       input logic lb, input logic lc, input logic ls,
                                       input logic as, input logic wr, input logic il,
                                       input logic ht);
        return {ew, ensel, evsel, la, lb, lc, ls, as, 1'b0, wr, il, ht};
    endfunction

    // Common expectations
    logic [14:0] E_WAIT, E_DEC, E_WIMM, E_GETA, E_GETB, E_WREG, E_ILL;

    task automatic chk(input string tag, input logic [14:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        E_WAIT = ev(1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        E_DEC  = ev(0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        E_WIMM = ev(0, 3'b001, 2'b01, 0, 0, 0, 0, 0, 1, 0, 0);
        E_GETA = ev(0, 3'b001, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);
        E_GETB = ev(0, 3'b100, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0);
        E_WREG = ev(0, 3'b010, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0);
        E_ILL  = ev(0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);

        // Reset state
        tick(); tick();
        chk("reset", E_WAIT);
        rst_n = 1'b1;

        // ADD interrupted by reset in GET_A
        opcode = 3'b101; op = 2'b00; s = 1'b1;
        tick(); chk("rst_add_decode", E_DEC);
        s = 1'b0;
        tick(); chk("rst_add_geta", E_GETA);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_midgeta", E_WAIT);
        #2 rst_n = 1'b1;

        // MOV imm; latency 2
        opcode = 3'b110; op = 2'b10; s = 1'b1;
        tick(); chk("movi_decode", E_DEC);
        s = 1'b0;
        tick(); chk("movi_write", E_WIMM);
        tick(); chk("movi_done", E_WAIT);

        // ADD; latency 5
        opcode = 3'b101; op = 2'b00; s = 1'b1;
        tick(); chk("add_decode", E_DEC);
        s = 1'b0;
        tick(); chk("add_geta", E_GETA);
        tick(); chk("add_getb", E_GETB);
        tick(); chk("add_alu", ev(0, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
        tick(); chk("add_wreg", E_WREG);
        tick(); chk("add_done", E_WAIT);

        // CMP; latency 4, loads only
        opcode = 3'b101; op = 2'b01; s = 1'b1;
        tick(); chk("cmp_decode", E_DEC);
        s = 1'b0;
        tick(); chk("cmp_geta", E_GETA);
        tick(); chk("cmp_getb", E_GETB);
        tick(); chk("cmp_alu", ev(0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0));
        tick(); chk("cmp_done", E_WAIT);

        // AND with inputs changed to MOV imm after the sampling edge
        opcode = 3'b101; op = 2'b10; s = 1'b1;
        tick(); chk("and_decode", E_DEC);
        s = 1'b0; opcode = 3'b110; op = 2'b10;
        tick(); chk("and_geta", E_GETA);
        tick(); chk("and_getb", E_GETB);
        tick(); chk("and_alu", ev(0, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
        tick(); chk("and_wreg", E_WREG);
        tick(); chk("and_done", E_WAIT);

        // MVN then MOV reg back-to-back with s held high
        opcode = 3'b101; op = 2'b11; s = 1'b1;
        tick(); chk("mvn_decode", E_DEC);
        tick(); chk("mvn_getb", E_GETB);
        tick(); chk("mvn_alu", ev(0, 3'b000, 2'b00, 0, 0, 1, 0, 1, 0, 0, 0));
        tick(); chk("mvn_wreg", E_WREG);
        opcode = 3'b110; op = 2'b00;
        tick(); chk("b2b_wait", E_WAIT);
        tick(); chk("movr_decode", E_DEC);
        s = 1'b0;
        tick(); chk("movr_getb", E_GETB);
        tick(); chk("movr_alu", ev(0, 3'b000, 2'b00, 0, 0, 1, 0, 1, 0, 0, 0));
        tick(); chk("movr_wreg", E_WREG);
        tick(); chk("movr_done", E_WAIT);

        // Illegal: opcode 100, and MOV with op 01
        opcode = 3'b100; op = 2'b00; s = 1'b1;
        tick(); chk("ill_opc_decode", E_ILL);
        s = 1'b0;
        tick(); chk("ill_opc_done", E_WAIT);
        opcode = 3'b110; op = 2'b01; s = 1'b1;
        tick(); chk("ill_op_decode", E_ILL);
        s = 1'b0;
        tick(); chk("ill_op_done", E_WAIT);

        // Opcode 111
        opcode = 3'b111; op = 2'b00; s = 1'b1;
`ifdef CPU_CTRL_HALT_EN
        tick(); chk("halt_decode", E_DEC);
        for (int i = 0; i < 20; i++) begin
            s = (i % 2 == 1);
            tick(); chk("halt_hold", ev(0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
        end
        #2 rst_n = 1'b0;
        #1 chk("halt_reset", E_WAIT);
        #2 rst_n = 1'b1;
        s = 1'b0;
`else
        tick(); chk("opc111_decode", E_ILL);
        s = 1'b0;
        tick(); chk("opc111_done", E_WAIT);
`endif

        // Sanity after everything: a fresh MOV imm still works
        opcode = 3'b110; op = 2'b10; s = 1'b1;
        tick(); chk("final_decode", E_DEC);
        s = 1'b0;
        tick(); chk("final_write", E_WIMM);
        tick(); chk("final_done", E_WAIT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Multicycle control FSM directly downstream of the instruction decoder.
- Consumes the decoded opcode/op fields and sequences the register-file/ALU datapath through read, execute and write-back.
- Drives all datapath load, select and write strobes.
- Handshakes with the top level via start (s) and wait (w).

Parameters:
- STATE_BITS, 4, width of the state register (must hold all encodings in the package).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- s  input  1  start; sampled only in WAIT
- opcode  input  3  decoded opcode field
- op  input  2  decoded op field
- w  output  1  1 = idle, ready for s
- nsel  output  3  one-hot regfile port select: 001 Rn, 010 Rd, 100 Rm, 000 none
- vsel  output  2  write-back source: 00 ALU result C, 01 sximm8, 10/11 reserved (never driven)
- loada  output  1  load A register
- loadb  output  1  load B register
- loadc  output  1  load C register
- loads  output  1  load status flags
- asel  output  1  1 = force ALU A input to zero
- bsel  output  1  1 = ALU B input is sximm5; always 0 in this ISA subset
- write  output  1  regfile write enable
- illegal  output  1  one-cycle pulse on undecodable instruction
- halted  output  1  1 = core halted (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset state: state=WAIT, latched opcode/op=0, w=1, all other outputs 0. Reset asserted mid-instruction returns to WAIT immediately; write drops without waiting for a clock edge.
- Output style: Moore outputs, decoded from the state and the latched opcode/op only. Any strobe not listed for a state is 0.
- Latching: in WAIT with s=1, opcode/op are latched internally. Later changes on the inputs are ignored until the next WAIT. s is ignored outside WAIT.
- WAIT: w=1.
  - s=1 -> DECODE.
- DECODE: w=0.
  - 110/10 (MOV imm) -> WRITE_IMM
  - 110/00 (MOV reg) -> GET_B
  - 101/11 (MVN) -> GET_B
  - 101/00 (ADD), 101/01 (CMP), 101/10 (AND) -> GET_A
  - any other value -> WAIT with illegal=1 for this cycle
- WRITE_IMM: nsel=001, vsel=01, write=1 -> WAIT.
- GET_A: nsel=001, loada=1 -> GET_B.
- GET_B: nsel=100, loadb=1 -> ALU.
- ALU: asel=1 for MOV reg and MVN.
  - CMP: loads=1, loadc=0 -> WAIT.
  - All other ALU ops: loadc=1 -> WRITE_REG.
- WRITE_REG: nsel=010, vsel=00, write=1 -> WAIT.
- Latency, counted as cycles from the clk edge sampling s=1 to the edge returning w=1:
  - MOV imm 2
  - illegal 1
  - MOV reg / MVN 4
  - CMP 4
  - ADD / AND 5
- Back-to-back: s held high makes WAIT last exactly one cycle between instructions.
- State register: never holds an unused encoding. The default branch -> WAIT.

Optional Feature:
- Macro: CPU_CTRL_HALT_EN.
- Defined: opcode 111 in DECODE -> HALT.
  - HALT: w=0, halted=1, all strobes 0, s ignored.
  - Only rst_n leaves HALT.
- Undefined: opcode 111 is illegal (1-cycle pulse, back to WAIT), and halted is tied 0.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum
  - opcode constants: OPC_MOV=3'b110, OPC_ALU=3'b101, OPC_HALT=3'b111
  - op constants: ADD, CMP, AND, MVN, MOV_IMM, MOV_REG
  - NSEL_RN/RD/RM/NONE
  - VSEL_C/IMM
- One combinational sub-module, cpu_ctrl_outdec, maps (state, latched opcode, latched op) to output strobes. The FSM next-state logic and latches stay in cpu_controller.

Test Plan:
- Reset: rst_n=0 asserted mid-GET_A -> immediately w=1 and all strobes 0. Release, then s=1 -> DECODE on the next edge.
- MOV imm: opcode=110, op=10, s pulse -> DECODE, then WRITE_IMM with nsel=001, vsel=01, write=1 for exactly 1 cycle. w=1 two cycles after the sampling edge.
- ADD: opcode=101, op=00 -> loada (nsel=001), loadb (nsel=100), loadc, then write (nsel=010, vsel=00), in consecutive cycles. loads never set.
- CMP: opcode=101, op=01 -> loads=1 in ALU, loadc=0, write never asserted. Back in WAIT after 4 cycles.
- Latch robustness: change opcode to 110/10 one cycle after s during an AND -> the AND sequence completes unchanged, with asel=0 throughout.
- Illegal/halt: opcode=111, s=1 -> without CPU_CTRL_HALT_EN, illegal=1 for 1 cycle then w=1. With CPU_CTRL_HALT_EN, halted=1 and w=0, held 20 cycles despite s toggling, cleared only by rst_n.
